// File: rtl/aes_key_expand.sv
// Iterative AES key-schedule engine: expands a 128/192/256-bit key into w[0..4*(NK+7)-1],
// streaming one round-key word per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start, outputs low
// RUN   | presenting w[idx], advancing on each accepted word
module aes_key_expand #(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_data,
    output logic [5:0]       w_index,
    output logic             busy,
    output logic             done
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    localparam logic [5:0] LAST_IDX = 6'(4 * (NK + 7) - 1);
    localparam logic [5:0] NK_IDX   = 6'(NK);
    localparam logic [2:0] PH_LAST  = 3'(NK - 1);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("aes_key_expand: NK must be 4, 6 or 8");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    logic        state_q, state_d;
    logic [31:0] window_q [NK];
    logic [31:0] window_d [NK];
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;

    logic [31:0] w_last;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] gen_word;
    logic [31:0] key_word;
    logic [31:0] cur_word;

    // One shared S-box row: phase 0 substitutes the rotated word, the NK=8 mid-phase the plain word.
    always_comb begin
        w_last  = window_q[NK-1];
        sub_in  = (phase_q == 3'd0) ? {w_last[23:0], w_last[31:24]} : w_last;
        sub_out = sub_word(sub_in);
        if (phase_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = w_last;
        end
        gen_word = window_q[0] ^ temp;
    end

    always_comb begin
        key_word = 32'h0;
        for (int k = 0; k < NK; k++) begin
            if (idx_q == 6'(k)) begin
                key_word = window_q[k];
            end
        end
        cur_word = (idx_q < NK_IDX) ? key_word : gen_word;
    end

    assign w_valid = (state_q == STATE_RUN);
    assign busy    = (state_q == STATE_RUN);
    assign w_data  = (state_q == STATE_RUN) ? cur_word : 32'h0;
    assign w_index = idx_q;
    assign done    = done_q;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        rcon_d   = rcon_q;
        done_d   = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    for (int k = 0; k < NK; k++) begin
                        window_d[k] = key_in[32*(NK-k)-1 -: 32];
                    end
                    idx_d   = 6'd0;
                    phase_d = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = STATE_RUN;
                end
            end
            default: begin
                if (w_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 6'd0;
                        done_d  = 1'b1;
                        state_d = STATE_IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        if (idx_q >= NK_IDX) begin
                            for (int k = 0; k < NK - 1; k++) begin
                                window_d[k] = window_q[k+1];
                            end
                            window_d[NK-1] = gen_word;
                            phase_d = (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
                            if (phase_q == 3'd0) begin
                                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            for (int k = 0; k < NK; k++) begin
                window_q[k] <= 32'h0;
            end
            idx_q   <= 6'd0;
            phase_q <= 3'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            rcon_q   <= rcon_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one instance per key length, checked against a textbook
// FIPS-197 key expansion with an S-box derived from GF(2^8) inverses.
module tb_aes_key_expand;

    logic         clk;
    logic         rst_n;
    logic         start_r;
    logic         ready_r;
    logic [255:0] key_r;
    int           sel;

    logic        v4, v6, v8, b4, b6, b8, dn4, dn6, dn8;
    logic [31:0] d4, d6, d8;
    logic [5:0]  i4, i6, i8;

    logic        cur_valid, cur_busy, cur_done;
    logic [31:0] cur_data;
    logic [5:0]  cur_idx;

    int passes = 0;
    int checks = 0;

    logic [7:0]  sbox_tab [256];
    logic [31:0] ref_w [64];
    logic [31:0] cap_d [64];
    logic [5:0]  cap_i [64];

    aes_key_expand #(.NK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_r && sel == 0), .key_in(key_r[255 -: 128]),
        .w_valid(v4), .w_ready(ready_r), .w_data(d4), .w_index(i4), .busy(b4), .done(dn4)
    );
    aes_key_expand #(.NK(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start_r && sel == 1), .key_in(key_r[255 -: 192]),
        .w_valid(v6), .w_ready(ready_r), .w_data(d6), .w_index(i6), .busy(b6), .done(dn6)
    );
    aes_key_expand #(.NK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_r && sel == 2), .key_in(key_r),
        .w_valid(v8), .w_ready(ready_r), .w_data(d8), .w_index(i8), .busy(b8), .done(dn8)
    );

    always_comb begin
        case (sel)
            0:       begin cur_valid = v4; cur_busy = b4; cur_done = dn4; cur_data = d4; cur_idx = i4; end
            1:       begin cur_valid = v6; cur_busy = b6; cur_done = dn6; cur_data = d6; cur_idx = i6; end
            default: begin cur_valid = v8; cur_busy = b8; cur_done = dn8; cur_data = d8; cur_idx = i8; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h0;
            logic [7:0] s;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv;
            for (int r = 1; r < 5; r++) s ^= (inv << r) | (inv >> (8 - r));
            sbox_tab[a] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic build_ref(input int nk);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                ref_w[i] = key_r[255 - 32 * i -: 32];
            end else begin
                t = ref_w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                ref_w[i] = ref_w[i-nk] ^ t;
            end
        end
    endtask

    // Call at a negedge; returns at the negedge where done is first seen (or on timeout).
    task automatic collect(input bit stall, output int got, output int unstable,
                           output int done_cyc, output int first_cyc, output logic bv_at_done);
        bit          pv_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        int          cyc = 0;
        got = 0; unstable = 0; done_cyc = -1; first_cyc = -1; bv_at_done = 1'b1;
        start_r = 1'b1;
        ready_r = 1'b1;
        while (cyc < 400 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start_r = 1'b0;
            if (cur_done) begin
                done_cyc   = cyc;
                bv_at_done = cur_busy | cur_valid;
            end
            if (cur_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (pv_stall && (cur_data !== pd || cur_idx !== pi)) unstable++;
                ready_r  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pv_stall = !ready_r;
                pd = cur_data;
                pi = cur_idx;
                if (ready_r) begin
                    if (got < 64) begin
                        cap_d[got] = cur_data;
                        cap_i[got] = cur_idx;
                    end
                    got++;
                end
            end else begin
                pv_stall = 1'b0;
                ready_r  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_r = 1'b0; ready_r = 1'b1; sel = 0; key_r = '0;
        #3;
        checks++;
        if ({v4, b4, dn4, i4, d4, v6, b6, dn6, i6, d6, v8, b8, dn8, i8, d8} !== '0)
            $display("FAIL reset_outputs: nonzero outputs in reset v=%b%b%b b=%b%b%b", v4, v6, v8, b4, b6, b8);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_kat(input int nk, input logic [255:0] key, input int ia, input logic [31:0] wa,
                            input int ib, input logic [31:0] wb, input int ic, input logic [31:0] wc);
        int got, unst, dcyc, fcyc;
        logic bv;
        int total = 4 * (nk + 7);
        sel = (nk == 4) ? 0 : (nk == 6) ? 1 : 2;
        key_r = key;
        build_ref(nk);
        collect(1'b0, got, unst, dcyc, fcyc, bv);
        checks++; if (got !== total) $display("FAIL kat%0d_count: got %0d words, need %0d", nk, got, total); else passes++;
        checks++; if (dcyc !== total + 1) $display("FAIL kat%0d_done_cycle: done at %0d, need %0d", nk, dcyc, total + 1); else passes++;
        checks++; if (fcyc !== 1) $display("FAIL kat%0d_first_cycle: first word at %0d, need 1", nk, fcyc); else passes++;
        checks++; if (bv !== 1'b0) $display("FAIL kat%0d_done_idle: busy|valid=%b at done, need 0", nk, bv); else passes++;
        checks++; if (cap_d[ia] !== wa) $display("FAIL kat%0d_w%0d: got %h need %h", nk, ia, cap_d[ia], wa); else passes++;
        checks++; if (cap_d[ib] !== wb) $display("FAIL kat%0d_w%0d: got %h need %h", nk, ib, cap_d[ib], wb); else passes++;
        checks++; if (cap_d[ic] !== wc) $display("FAIL kat%0d_w%0d: got %h need %h", nk, ic, cap_d[ic], wc); else passes++;
        for (int j = 0; j < total; j++) begin
            checks++;
            if (cap_d[j] !== ref_w[j] || cap_i[j] !== 6'(j))
                $display("FAIL kat%0d_seq[%0d]: got %h@%0d need %h@%0d", nk, j, cap_d[j], cap_i[j], ref_w[j], j);
            else passes++;
        end
        @(negedge clk);
        checks++; if (cur_done !== 1'b0) $display("FAIL kat%0d_done_pulse: done=%b one cycle later, need 0", nk, cur_done); else passes++;
    endtask

    task automatic test_stall();
        int got, unst, dcyc, fcyc;
        logic bv;
        sel = 0;
        key_r = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        build_ref(4);
        collect(1'b1, got, unst, dcyc, fcyc, bv);
        checks++; if (dcyc < 0) $display("FAIL stall_timeout: no done seen"); else passes++;
        checks++; if (got !== 44) $display("FAIL stall_count: got %0d words, need 44", got); else passes++;
        checks++; if (unst !== 0) $display("FAIL stall_stable: %0d unstable stall cycles, need 0", unst); else passes++;
        for (int j = 0; j < 44; j++) begin
            checks++;
            if (cap_d[j] !== ref_w[j] || cap_i[j] !== 6'(j))
                $display("FAIL stall_seq[%0d]: got %h@%0d need %h@%0d", j, cap_d[j], cap_i[j], ref_w[j], j);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored_and_reset();
        int got, unst, dcyc, fcyc, n, dn_seen;
        logic bv;
        sel = 0;
        key_r = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        build_ref(4);
        start_r = 1'b1; ready_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        n = 0;
        while (cur_idx !== 6'd20 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++; if (cur_idx !== 6'd20) $display("FAIL midrun_reach20: idx %0d, need 20", cur_idx); else passes++;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        checks++;
        if (cur_idx !== 6'd21 || cur_data !== ref_w[21] || cur_busy !== 1'b1)
            $display("FAIL midrun_start_ignored: got %h@%0d busy=%b need %h@21 busy=1", cur_data, cur_idx, cur_busy, ref_w[21]);
        else passes++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cur_valid, cur_busy, cur_done, cur_idx, cur_data} !== '0)
            $display("FAIL async_reset: valid=%b busy=%b idx=%0d data=%h, need all 0", cur_valid, cur_busy, cur_idx, cur_data);
        else passes++;
        dn_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cur_done) dn_seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (cur_done) dn_seen++;
        end
        checks++; if (dn_seen !== 0) $display("FAIL reset_no_done: done seen %0d times, need 0", dn_seen); else passes++;
        collect(1'b0, got, unst, dcyc, fcyc, bv);
        checks++; if (cap_d[4] !== 32'ha0fafe17) $display("FAIL restart_w4: got %h need a0fafe17", cap_d[4]); else passes++;
        checks++; if (cap_d[43] !== 32'hb6630ca6) $display("FAIL restart_w43: got %h need b6630ca6", cap_d[43]); else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int got, unst, dcyc, fcyc;
        logic bv;
        logic [31:0] last_a;
        sel = 0;
        key_r = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        build_ref(4);
        last_a = ref_w[43];
        collect(1'b0, got, unst, dcyc, fcyc, bv);
        checks++; if (cap_d[43] !== last_a || dcyc !== 45) $display("FAIL b2b_first_run: w43 %h done %0d need %h done 45", cap_d[43], dcyc, last_a); else passes++;
        key_r = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        build_ref(4);
        collect(1'b0, got, unst, dcyc, fcyc, bv);
        checks++; if (fcyc !== 1) $display("FAIL b2b_no_gap: new w0 at cycle %0d, need 1", fcyc); else passes++;
        checks++; if (cap_d[0] !== ref_w[0]) $display("FAIL b2b_w0: got %h need %h", cap_d[0], ref_w[0]); else passes++;
        checks++; if (got !== 44) $display("FAIL b2b_count: got %0d words, need 44", got); else passes++;
        for (int j = 0; j < 44; j++) begin
            checks++;
            if (cap_d[j] !== ref_w[j]) $display("FAIL b2b_seq[%0d]: got %h need %h", j, cap_d[j], ref_w[j]);
            else passes++;
        end
        @(negedge clk);
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_kat(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                 0, 32'h2b7e1516, 4, 32'ha0fafe17, 43, 32'hb6630ca6);
        test_kat(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                 0, 32'h8e73b0f7, 6, 32'hfe0c91f7, 51, 32'h01002202);
        test_kat(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                 8, 32'h9ba35411, 12, 32'ha8b09c1a, 59, 32'h706c631e);
        test_stall();
        test_start_ignored_and_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES key-schedule engine that expands a 128/192/256-bit cipher key into the full FIPS-197 word sequence w[0..4·(NK+7)−1]. It streams one 32-bit round-key word per accepted transfer on a valid/ready interface. It supersedes the fixed combinational word-rotate step by folding RotWord, SubWord and Rcon into a parametrised sequential datapath. It sits between the key register bank and the round-key store feeding the encrypt/decrypt cores.

## Interface
- NK, 4, key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256); any other value is an elaboration-time error
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin expansion; sampled only in IDLE
- key_in  in  32·NK  cipher key; key_in[32·NK−1 -: 32] is w[0] (FIPS byte order, MSB first)
- w_valid  out  1  w_data/w_index valid
- w_ready  in  1  consumer accepts word when w_valid && w_ready
- w_data  out  32  expanded word w[w_index]
- w_index  out  6  index of current word, 0..4·(NK+7)−1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: busy=0, w_valid=0. On start=1: window[0..NK−1] ← key words w[0..NK−1], idx ← 0, phase ← 0, rcon ← 8'h01, go to RUN. key_in is sampled only on this edge.
- RUN: w_valid=1, busy=1. w_index=idx.
- idx < NK: w_data = window[idx]; on accept idx increments, window unchanged.
- idx ≥ NK: temp = window[NK−1] (w[i−1]).
  - phase==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}.
  - NK==8 and phase==4: temp = SubWord(temp).
  - w_data = window[0] ^ temp (w[i−NK] ^ temp).
  - On accept: window shifts down one word, w_data enters at window[NK−1]. idx increments. phase wraps at NK−1 → 0. If phase was 0, rcon ← xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
- phase runs 0..NK−1 and tracks i mod NK without a divider. It is reset to 0 when idx reaches NK.
- RotWord: rotate left one byte, {b[23:0], b[31:24]}. SubWord: forward FIPS-197 S-box on each of the 4 bytes, combinational.
- Last word: idx = 4·(NK+7)−1, i.e. 43, 51 or 59. When it is accepted, go to IDLE and pulse done for one cycle.
- start while in RUN is ignored.
- Reset assertion at any time: asynchronous return to IDLE, all outputs low, partial sequence discarded. No done pulse.

## Timing
- Reset values: w_valid=0, w_data=0, w_index=0, busy=0, done=0. rcon=8'h01, idx=0, phase=0.
- start high at edge k → w_valid=1 with w[0] from cycle k+1.
- Throughput is one word per cycle while w_ready=1. A full AES-128 expansion takes 44 cycles after start with no stalls.
- w_data and w_index are combinational from registered state (window, idx, phase, rcon) through the S-box. No path exists from w_ready to w_data.
- While w_valid && !w_ready, w_data and w_index hold stable and no state advances.
- done is registered and high in the cycle after the final accept, coincident with busy=0 and w_valid=0. A start in that same cycle is accepted.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, w_ready=1 → w[0]=2b7e1516, w[4]=a0fafe17, w[43]=b6630ca6. done pulses once, 45 cycles after start.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → w[6]=fe0c91f7, w[51]=01002202. Exactly 52 words.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → w[8]=9ba35411, w[12]=a8b09c1a (phase-4 SubWord path), w[59]=706c631e.
- NK=4, random w_ready toggling with 50% duty → word sequence identical to the unstalled run. w_data and w_index are stable through every stall cycle. Total words = 44.
- Mid-run at idx=20: pulse start=1 → ignored, sequence continues. Then assert rst_n=0 asynchronously → w_valid, busy and w_index go to 0 immediately and no done pulse occurs. A fresh start then produces w[4]=a0fafe17 again, confirming rcon was reset.
- After done, start asserted in the done cycle with a new key → w[0] of the new key is presented on the next cycle, confirming no dead cycle between expansions.
